// File: rtl/pe_ctrl_fsm_gen.sv
// Control sequencer for the convolution PE array: kernel preload, tile streaming, channel/tile/group loops.
// Latency: read enables are Moore decodes of the state register; p_valid_out/last_chan_out lag PIPE_DLY cycles.
// Backpressure: stall freezes every register (state, counters, config, delay line); strobes hold while stalled.
// Optional build macro PE_CTRL_PERF_EN adds saturating perf_active/perf_stall counters.
module pe_ctrl_fsm_gen #(
    parameter int K_MAX    = 7,
    parameter int T_MAX    = 32,
    parameter int CH_GRP   = 8,
    parameter int PIPE_DLY = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             start_conv,
    input  logic             start_again,
    input  logic [2:0]       cfg_k,
    input  logic [5:0]       cfg_t,
    input  logic [CNT_W-1:0] cfg_ci,
    input  logic [CNT_W-1:0] cfg_co,
    input  logic [CNT_W-1:0] cfg_tiles,
    output logic             ifm_read,
    output logic             wgt_read,
    output logic             p_valid_out,
    output logic             last_chan_out,
    output logic             tile_done,
    output logic             end_conv,
    output logic             busy,
    output logic [CNT_W-1:0] tile_idx,
    output logic [CNT_W-1:0] co_idx
`ifdef PE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_active,
    output logic [31:0]      perf_stall
`endif
);

    // Column counter must reach T_MAX+K_MAX-2 (last column of the longest pass).
    localparam int COL_W = $clog2(T_MAX + K_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PASS = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state_q, state_nx;
    logic [COL_W-1:0] col_q, col_nx;
    logic [CNT_W-1:0] ch_q, ch_nx;
    logic [CNT_W-1:0] tile_q, tile_nx;
    logic [CNT_W-1:0] co_q, co_nx;
    logic             tile_done_q, tile_done_nx;

    // Latched layer configuration
    logic [COL_W-1:0] k_q, t_q;
    logic [CNT_W-1:0] ci_tot_q, co_tot_q, tiles_q;

    logic [COL_W-1:0] k_cl, t_cl;
    logic [COL_W-1:0] col_last;
    logic [CNT_W-1:0] ch_last;
    logic             start_ok;
    logic             p_valid;
    logic             last_chan;

    // A start is only taken from IDLE and only on a cycle that is not frozen.
    assign start_ok = (state_q == IDLE) && start_conv && !stall;

    // Last column of a pass is ROW-1 = t+k-2; k and t are both at least 1 once latched.
    assign col_last = k_q + t_q - COL_W'(2);
    assign ch_last  = ci_tot_q - CNT_W'(1);

    // Clamp runtime geometry into 1..MAX before it is latched.
    always_comb begin
        k_cl = COL_W'(cfg_k);
        if (cfg_k == 3'd0) begin
            k_cl = COL_W'(1);
        end else if (int'(cfg_k) > K_MAX) begin
            k_cl = COL_W'(K_MAX);
        end
        t_cl = COL_W'(cfg_t);
        if (cfg_t == 6'd0) begin
            t_cl = COL_W'(1);
        end else if (int'(cfg_t) > T_MAX) begin
            t_cl = COL_W'(T_MAX);
        end
    end

    // Capture geometry and loop totals on an accepted start; held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= '0;
            t_q      <= '0;
            ci_tot_q <= '0;
            co_tot_q <= '0;
            tiles_q  <= '0;
        end else if (start_ok) begin
            k_q      <= k_cl;
            t_q      <= t_cl;
            // Channel total wraps at CNT_W bits by construction.
            ci_tot_q <= (cfg_ci + CNT_W'(1)) * CNT_W'(CH_GRP);
            co_tot_q <= cfg_co + CNT_W'(1);
            tiles_q  <= cfg_tiles;
        end
    end

    // Next-state and loop-counter update; innermost loop is columns, then channels, tiles, groups.
    always_comb begin
        state_nx     = state_q;
        col_nx       = col_q;
        ch_nx        = ch_q;
        tile_nx      = tile_q;
        co_nx        = co_q;
        tile_done_nx = 1'b0;
        case (state_q)
            IDLE: begin
                // start_again arriving with start_conv is ignored here on purpose.
                if (start_conv) begin
                    col_nx  = '0;
                    ch_nx   = '0;
                    tile_nx = '0;
                    co_nx   = '0;
                    state_nx = (cfg_tiles == '0) ? FIN : WAIT;
                end
            end
            WAIT: begin
                if (start_again) begin
                    col_nx   = '0;
                    state_nx = PASS;
                end
            end
            PASS: begin
                if (col_q == col_last) begin
                    col_nx = '0;
                    if (ch_q < ch_last) begin
                        // Next input-channel pass follows back to back.
                        ch_nx = ch_q + CNT_W'(1);
                    end else begin
                        ch_nx        = '0;
                        tile_done_nx = 1'b1;
                        if (tile_q < tiles_q - CNT_W'(1)) begin
                            tile_nx  = tile_q + CNT_W'(1);
                            state_nx = WAIT;
                        end else begin
                            tile_nx = '0;
                            if (co_q < co_tot_q - CNT_W'(1)) begin
                                co_nx    = co_q + CNT_W'(1);
                                state_nx = WAIT;
                            end else begin
                                state_nx = FIN;
                            end
                        end
                    end
                end else begin
                    col_nx = col_q + COL_W'(1);
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and counter registers; a stalled cycle holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            ch_q        <= '0;
            tile_q      <= '0;
            co_q        <= '0;
            tile_done_q <= 1'b0;
        end else if (!stall) begin
            state_q     <= state_nx;
            col_q       <= col_nx;
            ch_q        <= ch_nx;
            tile_q      <= tile_nx;
            co_q        <= co_nx;
            tile_done_q <= tile_done_nx;
        end
    end

    // Moore decodes from registered state only; no input reaches an output combinationally.
    assign ifm_read  = (state_q == PASS);
    assign wgt_read  = (state_q == PASS) && (col_q < k_q);
    // Valid once the kernel window is full: exactly t cycles per pass.
    assign p_valid   = (state_q == PASS) && (col_q >= k_q - COL_W'(1));
    assign last_chan = p_valid && (ch_q == ch_last);
    assign tile_done = tile_done_q;
    assign end_conv  = (state_q == FIN);
    assign busy      = (state_q != IDLE);
    assign tile_idx  = tile_q;
    assign co_idx    = co_q;

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign p_valid_out   = p_valid;
            assign last_chan_out = last_chan;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] pv_sr;
            logic [PIPE_DLY-1:0] lc_sr;

            // Match the PE pipeline depth; advances only on non-stalled cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pv_sr <= '0;
                    lc_sr <= '0;
                end else if (!stall) begin
                    pv_sr[0] <= p_valid;
                    lc_sr[0] <= last_chan;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        pv_sr[i] <= pv_sr[i-1];
                        lc_sr[i] <= lc_sr[i-1];
                    end
                end
            end

            assign p_valid_out   = pv_sr[PIPE_DLY-1];
            assign last_chan_out = lc_sr[PIPE_DLY-1];
        end
    endgenerate

`ifdef PE_CTRL_PERF_EN
    // Saturating activity/stall counters, restarted by each accepted layer start.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            perf_active <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && !stall && (perf_active != '1)) begin
                perf_active <= perf_active + 32'd1;
            end
            if (busy && stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_ctrl_fsm_gen.sv
// Bench for pe_ctrl_fsm_gen: table of layer configurations with hand-computed strobe counts,
// plus directed sequences for stall shifting, mid-run reset, zero tiles and start collisions.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_pe_ctrl_fsm_gen;

    localparam int CNT_W    = 16;
    localparam int PIPE_DLY = 4;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             start_conv;
    logic             start_again;
    logic [2:0]       cfg_k;
    logic [5:0]       cfg_t;
    logic [CNT_W-1:0] cfg_ci;
    logic [CNT_W-1:0] cfg_co;
    logic [CNT_W-1:0] cfg_tiles;
    logic             ifm_read;
    logic             wgt_read;
    logic             p_valid_out;
    logic             last_chan_out;
    logic             tile_done;
    logic             end_conv;
    logic             busy;
    logic [CNT_W-1:0] tile_idx;
    logic [CNT_W-1:0] co_idx;
`ifdef PE_CTRL_PERF_EN
    logic [31:0]      perf_active;
    logic [31:0]      perf_stall;
`endif

    pe_ctrl_fsm_gen #(
        .K_MAX    (7),
        .T_MAX    (32),
        .CH_GRP   (8),
        .PIPE_DLY (PIPE_DLY),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .start_conv    (start_conv),
        .start_again   (start_again),
        .cfg_k         (cfg_k),
        .cfg_t         (cfg_t),
        .cfg_ci        (cfg_ci),
        .cfg_co        (cfg_co),
        .cfg_tiles     (cfg_tiles),
        .ifm_read      (ifm_read),
        .wgt_read      (wgt_read),
        .p_valid_out   (p_valid_out),
        .last_chan_out (last_chan_out),
        .tile_done     (tile_done),
        .end_conv      (end_conv),
        .busy          (busy),
        .tile_idx      (tile_idx),
        .co_idx        (co_idx)
`ifdef PE_CTRL_PERF_EN
        ,
        .perf_active   (perf_active),
        .perf_stall    (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    typedef struct {
        int k, t, ci, co, tl;
        int e_ifm, e_wgt, e_pvo, e_lco, e_td, e_wait;
    } vec_t;

    vec_t vecs[7];

    // Per-run observations (non-held samples only)
    logic [6:0] trace[$];
    logic [6:0] ref_tr[$];
    int n_ifm, n_wgt, n_pvo, n_lco, n_td, n_end, n_wait;
    int first_ifm, last_ifm, first_pvo;
    int held_cnt, held_bad;
    int stall_left;
    bit finished;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] out_vec();
        return {busy, end_conv, tile_done, last_chan_out, p_valid_out, wgt_read, ifm_read};
    endfunction

    // Run one layer, answering every WAIT with start_again; optional 5-cycle stalls at
    // column stall_at of the first pass and during FIN.
    task automatic run_cfg(input int k, input int t, input int ci, input int co, input int tl,
                           input int stall_at, input bit stall_fin);
        logic [6:0] s;
        bit held, st_done, fin_done, seen_end, prev_end;
        int post, idx;
        trace.delete();
        n_ifm = 0; n_wgt = 0; n_pvo = 0; n_lco = 0; n_td = 0; n_end = 0; n_wait = 0;
        first_ifm = -1; last_ifm = -1; first_pvo = -1;
        held_cnt = 0; held_bad = 0; stall_left = 0;
        st_done = 0; fin_done = 0; seen_end = 0; prev_end = 0; post = 0; finished = 0;
        cfg_k = 3'(k); cfg_t = 6'(t);
        cfg_ci = CNT_W'(ci); cfg_co = CNT_W'(co); cfg_tiles = CNT_W'(tl);
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            s = out_vec();
            held = stall;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end
            start_again = 1'b0;
            if (held) begin
                held_cnt++;
                if (s !== trace[$]) held_bad++;
            end else begin
                trace.push_back(s);
                idx = trace.size() - 1;
                if (prev_end) chk("busy_fall_after_end", {busy, end_conv}, 2'b00);
                n_ifm += int'(ifm_read);
                n_wgt += int'(wgt_read);
                n_pvo += int'(p_valid_out);
                n_lco += int'(last_chan_out);
                n_td  += int'(tile_done);
                n_end += int'(end_conv);
                if (ifm_read) begin
                    if (first_ifm < 0) first_ifm = idx;
                    last_ifm = idx;
                end
                if (p_valid_out && first_pvo < 0) first_pvo = idx;
                if (busy && !ifm_read && !end_conv) begin
                    chk("wait_tile_idx", tile_idx, (tl > 0) ? (n_wait % tl) : -1);
                    chk("wait_co_idx", co_idx, (tl > 0) ? (n_wait / tl) : -1);
                    n_wait++;
                    start_again = 1'b1;
                end
                if (stall_at >= 0 && !st_done && ifm_read && (idx - first_ifm) == stall_at) begin
                    stall = 1'b1; stall_left = 5; st_done = 1;
                end
                if (stall_fin && !fin_done && end_conv) begin
                    stall = 1'b1; stall_left = 5; fin_done = 1;
                end
                prev_end = end_conv;
                if (end_conv) seen_end = 1;
                if (seen_end && !busy) begin
                    post++;
                    if (post >= PIPE_DLY + 3) finished = 1;
                end
            end
            if (!finished) tick();
        end
        chk("run_completed", finished, 1);
    endtask

    initial begin
        int ends, nmis;
        total = 0; bad = 0;
        rst = 1'b1; stall = 1'b0; start_conv = 1'b0; start_again = 1'b0;
        cfg_k = '0; cfg_t = '0; cfg_ci = '0; cfg_co = '0; cfg_tiles = '0;

        //                k  t  ci co tl  ifm  wgt  pvo  lco td wait
        vecs[0] = '{3, 14, 0, 0, 1, 128,  24, 112,  14, 1, 1};
        vecs[1] = '{3, 14, 1, 0, 1, 256,  48, 224,  14, 1, 1};
        vecs[2] = '{1,  4, 0, 1, 2, 128,  32, 128,  16, 4, 4};
        vecs[3] = '{0,  5, 0, 0, 1,  40,   8,  40,   5, 1, 1};
        vecs[4] = '{7,  0, 0, 0, 1,  56,  56,   8,   1, 1, 1};
        vecs[5] = '{2, 63, 0, 0, 1, 264,  16, 256,  32, 1, 1};
        vecs[6] = '{3, 14, 0, 0, 0,   0,   0,   0,   0, 0, 0};

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", out_vec(), 7'd0);
        chk("reset_tile_idx", tile_idx, 0);
        chk("reset_co_idx", co_idx, 0);
        rst = 1'b0;
        tick();

        // Table-driven layers
        for (int i = 0; i < 7; i++) begin
            run_cfg(vecs[i].k, vecs[i].t, vecs[i].ci, vecs[i].co, vecs[i].tl, -1, 1'b0);
            chk($sformatf("v%0d_ifm", i), n_ifm, vecs[i].e_ifm);
            chk($sformatf("v%0d_wgt", i), n_wgt, vecs[i].e_wgt);
            chk($sformatf("v%0d_pvo", i), n_pvo, vecs[i].e_pvo);
            chk($sformatf("v%0d_lco", i), n_lco, vecs[i].e_lco);
            chk($sformatf("v%0d_tdone", i), n_td, vecs[i].e_td);
            chk($sformatf("v%0d_end", i), n_end, 1);
            chk($sformatf("v%0d_waits", i), n_wait, vecs[i].e_wait);
            // Single-tile layers stream every channel pass back to back.
            if (vecs[i].e_wait == 1)
                chk($sformatf("v%0d_pass_span", i), last_ifm - first_ifm, vecs[i].e_ifm - 1);
            if (i == 0) begin
                chk("single_first_ifm", first_ifm, 1);
                chk("single_pvo_delay", first_pvo - first_ifm, 2 + PIPE_DLY);
            end
            if (i == 6) begin
                chk("tiles0_end_first_cycle", trace[0][5], 1'b1);
                chk("tiles0_idle_next", trace[1][6], 1'b0);
            end
            tick();
        end

        // Stall: reference run, then the same layer with stalls at col 7 and in FIN
        run_cfg(3, 14, 0, 0, 1, -1, 1'b0);
        ref_tr = trace;
        tick();
        run_cfg(3, 14, 0, 0, 1, 7, 1'b1);
        chk("stall_held_cycles", held_cnt, 10);
        chk("stall_held_changed", held_bad, 0);
        chk("stall_trace_len", trace.size(), ref_tr.size());
        nmis = 0;
        for (int j = 0; j < trace.size() && j < ref_tr.size(); j++)
            if (trace[j] !== ref_tr[j]) nmis++;
        chk("stall_trace_diff", nmis, 0);
        chk("stall_pvo_count", n_pvo, 112);
        tick();

        // Reset mid-pass at col 5: k=1 so the delay line is already carrying valids
        cfg_k = 3'd1; cfg_t = 6'd14; cfg_ci = '0; cfg_co = 16'd1; cfg_tiles = 16'd2;
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
        start_again = 1'b1;
        tick();
        start_again = 1'b0;
        repeat (5) tick();
        chk("mid_pvo_before_rst", {ifm_read, p_valid_out}, 2'b11);
        rst = 1'b1;
        tick();
        chk("mid_rst_outputs", out_vec(), 7'd0);
        chk("mid_rst_tile_idx", tile_idx, 0);
        chk("mid_rst_co_idx", co_idx, 0);
        rst = 1'b0;
        ends = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            ends += int'(end_conv);
        end
        chk("mid_rst_no_end", ends, 0);
        chk("mid_rst_idle", busy, 1'b0);

        // start_conv and start_again together in IDLE: only the start acts
        cfg_k = 3'd3; cfg_t = 6'd4; cfg_ci = '0; cfg_co = '0; cfg_tiles = 16'd1;
        start_conv = 1'b1;
        start_again = 1'b1;
        tick();
        start_conv = 1'b0;
        start_again = 1'b0;
        chk("collide_wait", {busy, ifm_read}, 2'b10);
        tick();
        chk("collide_still_wait", {busy, ifm_read}, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
